// File: rtl/mem_pkg.sv
// Shared types and constants for the dual-port memory block.
package mem_pkg;
    typedef enum logic {CLEAR, RUN} mem_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
endpackage

// File: rtl/dual_port_memory_if.sv
// Write/read/clear bus of the dual-port memory; the memory sits on the slave side.
interface dual_port_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    writeEnable;
    logic [ADDR_WIDTH-1:0]   writeAddr;
    logic [DATA_WIDTH-1:0]   writeData;
    logic [DATA_WIDTH/8-1:0] writeByteEn;
    logic                    readEnable;
    logic [ADDR_WIDTH-1:0]   readAddr;
    logic [DATA_WIDTH-1:0]   readData;
    logic                    readValid;
    logic                    clearRequest;
    logic                    initBusy;

    modport master (
        output writeEnable, writeAddr, writeData, writeByteEn,
        output readEnable, readAddr, clearRequest,
        input  readData, readValid, initBusy
    );

    modport slave (
        input  writeEnable, writeAddr, writeData, writeByteEn,
        input  readEnable, readAddr, clearRequest,
        output readData, readValid, initBusy
    );
endinterface

// File: rtl/mem_read_pipe.sv
// Delay line for read results; each data stage loads only with a valid beat so the
// output word holds its last value between strobes.
module mem_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clock ^ reset;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [STAGES:1]                 vld_pipe;
            logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[1] <= in_valid;
                    if (in_valid) dat_pipe[1] <= in_data;
                    for (int k = 2; k <= STAGES; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
                    end
                end
            end

            assign out_valid = vld_pipe[STAGES];
            assign out_data  = dat_pipe[STAGES];
        end
    endgenerate
endmodule

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM with byte enables, pipelined reads, selectable read-during-write
// policy and a clear engine that zeroes the array after reset or on request.
module dual_port_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_READ_FIRST
) (
    input logic               clock,
    input logic               reset,
    dual_port_memory_if.slave bus
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("dual_port_memory: DATA_WIDTH must be a multiple of 8");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("dual_port_memory: READ_LATENCY must be in 1..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mem_state_t            state, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BYTES-1:0]      mem_be;
    logic                  rd_acc;
    logic                  wr_in_range, rd_in_range, wr_hit;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_q;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign wr_in_range = ({1'b0, bus.writeAddr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.readAddr}  < DEPTH_EXT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_d;
            clr_cnt <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        clr_cnt_d = clr_cnt;
        mem_we    = 1'b0;
        mem_addr  = bus.writeAddr;
        mem_wdata = bus.writeData;
        mem_be    = bus.writeByteEn;
        rd_acc    = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = '0;
                mem_be    = '1;
                clr_cnt_d = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == LAST_ADDR) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                mem_we = bus.writeEnable && wr_in_range;
                rd_acc = bus.readEnable;
                if (bus.clearRequest) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign bus.initBusy = (state == CLEAR);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Write-first merges the incoming bytes over the pre-write word on an address hit.
    assign wr_hit = bus.writeEnable && wr_in_range && (bus.writeAddr == bus.readAddr);
    assign rd_old = rd_in_range ? mem[bus.readAddr] : '0;

    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == RDW_WRITE_FIRST && wr_hit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.writeByteEn[b]) rd_word[8*b +: 8] = bus.writeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_q   <= '0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_acc) rd_q <= rd_word;
        end
    end

    mem_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READ_LATENCY - 1)
    ) u_read_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_vld),
        .in_data   (rd_q),
        .out_valid (bus.readValid),
        .out_data  (bus.readData)
    );
endmodule

// File: tb/tb_dual_port_memory.sv
// Directed bench: three memories (depth/latency/RDW variants) driven by one stimulus stream.
module tb_dual_port_memory;
    function automatic int dep_of(input int g); return (g == 2) ? 12 : 16; endfunction
    function automatic int rl_of(input int g);  return (g == 0) ? 1 : (g == 1) ? 3 : 2; endfunction
    function automatic int rdw_of(input int g); return (g == 1) ? 1 : 0; endfunction

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, re = 1'b0, cr = 1'b0;
    logic [3:0]  wa = '0, ra = '0, be = '0;
    logic [31:0] wd = '0;

    logic [2:0]  rvld, busy;
    logic [31:0] rdat [3];
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;

    typedef struct { int d; logic [31:0] data; int cyc; } rd_t;
    rd_t rq[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dual_port_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifs [3] ();

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            assign ifs[g].writeEnable  = we;
            assign ifs[g].writeAddr    = wa;
            assign ifs[g].writeData    = wd;
            assign ifs[g].writeByteEn  = be;
            assign ifs[g].readEnable   = re;
            assign ifs[g].readAddr     = ra;
            assign ifs[g].clearRequest = cr;
            assign rvld[g] = ifs[g].readValid;
            assign rdat[g] = ifs[g].readData;
            assign busy[g] = ifs[g].initBusy;

            dual_port_memory #(
                .DATA_WIDTH   (32),
                .DEPTH        (dep_of(g)),
                .READ_LATENCY (rl_of(g)),
                .RDW_MODE     (rdw_of(g))
            ) u_dut (
                .clock (clock),
                .reset (reset),
                .bus   (ifs[g])
            );
        end
    endgenerate

    always @(negedge clock) begin
        for (int d = 0; d < 3; d++)
            if (rvld[d]) rq.push_back('{d, rdat[d], cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int d);
        int n = 0;
        foreach (rq[i]) if (rq[i].d == d) n++;
        return n;
    endfunction

    function automatic rd_t nth_of(input int d, input int k);
        int n = 0;
        rd_t r = '{-1, 32'hx, -1};
        foreach (rq[i]) begin
            if (rq[i].d == d) begin
                if (n == k) r = rq[i];
                n++;
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] data, input logic [3:0] mask);
        we = 1'b1; wa = a; wd = data; be = mask;
        tick;
        we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        rq.delete();
        re = 1'b1; ra = a;
        tick;
        re = 1'b0;
        repeat (5) tick;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_cnt_d%0d", tag, d), cnt_of(d), 1);
            chk($sformatf("%s_d%0d", tag, d), nth_of(d, 0).data, e[d]);
        end
    endtask

    task automatic read_all_zero(input string tag);
        logic [31:0] acc;
        rq.delete();
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra = 4'(a);
            tick;
        end
        re = 1'b0;
        repeat (6) tick;
        for (int d = 0; d < 3; d++) begin
            acc = '0;
            for (int k = 0; k < 16; k++) acc = acc | nth_of(d, k).data;
            chk($sformatf("%s_cnt_d%0d", tag, d), cnt_of(d), 16);
            chk($sformatf("%s_or_d%0d", tag, d), acc, 0);
        end
    endtask

    // Counts busy negedges per memory over a bounded window; optionally drops we/re.
    task automatic count_busy(input string tag, input int drop_at);
        int n [3];
        n = '{0, 0, 0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) if (busy[d]) n[d]++;
            if (i == drop_at) begin we = 1'b0; re = 1'b0; end
        end
        for (int d = 0; d < 3; d++) chk($sformatf("%s_busy_d%0d", tag, d), n[d], dep_of(d));
    endtask

    initial begin
        int c0;
        logic [31:0] pat;

        repeat (3) tick;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy_d%0d", d), busy[d], 1);
            chk($sformatf("rst_vld_d%0d", d), rvld[d], 0);
            chk($sformatf("rst_data_d%0d", d), rdat[d], 0);
        end
        tick;
        reset = 1'b0;
        count_busy("boot", -1);
        read_all_zero("boot_rd");

        wr(4'd5, 32'hDEADBEEF, 4'b1111);
        wr(4'd5, 32'h11223344, 4'b0101);
        read_chk("be5", 4'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

        wr(4'd1, 32'h11111111, 4'b1111);
        wr(4'd2, 32'h22222222, 4'b1111);
        wr(4'd3, 32'h33333333, 4'b1111);
        rq.delete();
        c0 = cyc;
        for (int a = 1; a <= 3; a++) begin
            re = 1'b1; ra = 4'(a);
            tick;
        end
        re = 1'b0;
        repeat (6) tick;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("b2b_cnt_d%0d", d), cnt_of(d), 3);
            for (int k = 0; k < 3; k++) begin
                pat = 32'h11111111 * (k + 1);
                chk($sformatf("b2b_dat%0d_d%0d", k, d), nth_of(d, k).data, pat);
                chk($sformatf("b2b_cyc%0d_d%0d", k, d), nth_of(d, k).cyc, c0 + rl_of(d) + k);
            end
        end

        wr(4'd7, 32'hAAAAAAAA, 4'b1111);
        rq.delete();
        we = 1'b1; wa = 4'd7; wd = 32'h55555555; be = 4'b1111; re = 1'b1; ra = 4'd7;
        tick;
        we = 1'b0; re = 1'b0;
        repeat (5) tick;
        for (int d = 0; d < 3; d++)
            chk($sformatf("rdw_full_d%0d", d), nth_of(d, 0).data,
                rdw_of(d) ? 32'h55555555 : 32'hAAAAAAAA);
        rq.delete();
        we = 1'b1; wa = 4'd7; wd = 32'h12345678; be = 4'b0011; re = 1'b1; ra = 4'd7;
        tick;
        we = 1'b0; re = 1'b0;
        repeat (5) tick;
        for (int d = 0; d < 3; d++)
            chk($sformatf("rdw_part_d%0d", d), nth_of(d, 0).data,
                rdw_of(d) ? 32'h55555678 : 32'h55555555);
        read_chk("rdw_after", 4'd7, 32'h55555678, 32'h55555678, 32'h55555678);

        wr(4'd13, 32'hCAFEF00D, 4'b1111);
        read_chk("oor13", 4'd13, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
        read_chk("alias1", 4'd1, 32'h11111111, 32'h11111111, 32'h11111111);

        for (int a = 0; a < 16; a++) wr(4'(a), 32'hF0000000 | a, 4'b1111);
        read_chk("fill9", 4'd9, 32'hF0000009, 32'hF0000009, 32'hF0000009);
        cr = 1'b1;
        tick;
        cr = 1'b0;
        rq.delete();
        we = 1'b1; wa = 4'd2; wd = 32'hFFFFFFFF; be = 4'b1111; re = 1'b1; ra = 4'd2;
        count_busy("clr", 9);
        for (int d = 0; d < 3; d++) chk($sformatf("clr_novld_d%0d", d), cnt_of(d), 0);
        tick;
        read_all_zero("clr_rd");

        wr(4'd4, 32'h44444444, 4'b1111);
        rq.delete();
        re = 1'b1; ra = 4'd4;
        tick;
        re = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("kill_vld_d%0d", d), rvld[d], 0);
            chk($sformatf("kill_data_d%0d", d), rdat[d], 0);
        end
        repeat (2) tick;
        for (int d = 0; d < 3; d++) chk($sformatf("kill_busy_d%0d", d), busy[d], 1);
        reset = 1'b0;
        count_busy("rst2", -1);
        for (int d = 0; d < 3; d++) chk($sformatf("kill_novld_d%0d", d), cnt_of(d), 0);
        tick;
        read_chk("rst_rd4", 4'd4, 32'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
